key_conditioner: RTL and testbench

Front-end conditioning stage for the audio recorder/player top level. It sits between the board pushbuttons and slide switches and the control FSM's `i_key_*` and `i_sw_*` inputs. It synchronizes all six raw inputs into `i_clk` and debounces them. For each key it emits a single-cycle press pulse; for each switch it emits a stable level. As a build option, the two speed keys auto-repeat while held.

---
 rtl/key_conditioner.sv | 120 ++++++++++++
 tb/tb_key_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Synchronizes and debounces four active-low pushbuttons and two slide switches.
// Define KEY_AUTOREPEAT_EN to make keys 2 and 3 auto-repeat while held.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 24000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key_n,
  input  logic [1:0] i_sw,
  output logic [3:0] o_key_press,
  output logic [3:0] o_key_level,
  output logic [1:0] o_sw
);

  // Channels 0..3 are keys (raw active-low), 4..5 are switches.
  localparam logic [5:0]       SYNC_RST = 6'b00_1111;
  localparam logic [5:0]       ACT_LOW  = 6'b00_1111;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       raw;
  logic [5:0]       meta;
  logic [5:0]       sync;
  logic [5:0]       synced;
  logic [5:0]       stable;
  logic [5:0]       stable_nxt;
  logic [5:0]       toggle;
  logic [3:0]       press_evt;
  logic [3:0]       rep_fire;
  logic [CNT_W-1:0] cnt [6];

  assign raw    = {i_sw, i_key_n};
  assign synced = sync ^ ACT_LOW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= SYNC_RST;
      sync <= SYNC_RST;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_comb begin
    toggle = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      toggle[i] = (synced[i] != stable[i]) && (cnt[i] == DB_LAST);
    end
    stable_nxt = stable ^ toggle;
    press_evt  = toggle[3:0] & ~stable[3:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int unsigned i = 0; i < 6; i++) begin
        if ((synced[i] == stable[i]) || toggle[i]) cnt[i] <= '0;
        else                                       cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt [2];
  logic [1:0]       rphase;
  logic [1:0]       rfire;

  // Gating on stable_nxt lets a release stop repeats on the same edge it lands.
  always_comb begin
    rfire = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      rfire[k] = stable_nxt[k+2] && !press_evt[k+2] &&
                 (rcnt[k] == (rphase[k] ? RP_LAST : RD_LAST));
    end
  end

  assign rep_fire = {rfire, 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rphase <= '0;
      for (int unsigned k = 0; k < 2; k++) rcnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (!stable_nxt[k+2] || press_evt[k+2]) begin
          rcnt[k]   <= '0;
          rphase[k] <= 1'b0;
        end else if (rfire[k]) begin
          rcnt[k]   <= '0;
          rphase[k] <= 1'b1;
        end else begin
          rcnt[k]   <= rcnt[k] + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_key_press <= '0;
    else          o_key_press <= press_evt | rep_fire;
  end

  assign o_key_level = stable[3:0];
  assign o_sw        = stable[5:4];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected output events,
// a negedge monitor pops and compares every output change or press pulse.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_n;
  logic [1:0] sw;
  logic [3:0] key_press;
  logic [3:0] key_level;
  logic [1:0] sw_out;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_n    (key_n),
    .i_sw       (sw),
    .o_key_press(key_press),
    .o_key_level(key_level),
    .o_sw       (sw_out)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] level;
    logic [1:0] sw;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rst_chk = 1'b0;
  logic done = 1'b0;
  logic [3:0] prev_level = '0;
  logic [1:0] prev_sw = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic [3:0] l, input logic [1:0] s);
    ev_t e;
    e.cyc = at; e.press = p; e.level = l; e.sw = s;
    q.push_back(e);
  endtask

  // Monitor: the only process that counts checks and errors.
  always @(negedge clk) begin
    ev_t e;
    if (rst_chk) begin
      checks++;
      if (key_press != '0 || key_level != '0 || sw_out != '0) begin
        errors++;
        $display("FAIL reset_state: press=%b level=%b sw=%b, required all zero", key_press, key_level, sw_out);
      end
    end
    if (key_press != '0 || key_level != prev_level || sw_out != prev_sw) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d press=%b level=%b sw=%b, none expected", cyc, key_press, key_level, sw_out);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.press != key_press || e.level != key_level || e.sw != sw_out) begin
          errors++;
          $display("FAIL event: got cyc=%0d press=%b level=%b sw=%b, required cyc=%0d press=%b level=%b sw=%b",
                   cyc, key_press, key_level, sw_out, e.cyc, e.press, e.level, e.sw);
        end
      end
    end
    prev_level = key_level;
    prev_sw    = sw_out;
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL missing_events: %0d expected events never seen, next at cyc=%0d", q.size(), q[0].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    key_n = 4'hF;
    sw    = 2'b00;
    step(3);
    #2 rst_chk = 1'b1;
    step(1);
    #2 rst_chk = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);

    // Clean press and release on key 0
    c = cyc;
    push(c + 6, 4'b0001, 4'b0001, 2'b00);
    push(c + 26, 4'b0000, 4'b0000, 2'b00);
    key_n[0] = 1'b0;
    step(20);
    key_n[0] = 1'b1;
    step(10);

    // Glitches of 3 cycles on key 1 are rejected
    repeat (5) begin
      key_n[1] = 1'b0;
      step(3);
      key_n[1] = 1'b1;
      step(3);
    end
    step(4);

    // A 4-cycle low on key 1 is just long enough to be accepted
    c = cyc;
    push(c + 6, 4'b0010, 4'b0010, 2'b00);
    push(c + 10, 4'b0000, 4'b0000, 2'b00);
    key_n[1] = 1'b0;
    step(4);
    key_n[1] = 1'b1;
    step(10);

    // Simultaneous press on keys 2 and 3, released before any repeat
    c = cyc;
    push(c + 6, 4'b1100, 4'b1100, 2'b00);
    push(c + 14, 4'b0000, 4'b0000, 2'b00);
    key_n[3:2] = 2'b00;
    step(8);
    key_n[3:2] = 2'b11;
    step(10);

    // Switch 0 rises with a 2-cycle bounce
    c = cyc;
    push(c + 9, 4'b0000, 4'b0000, 2'b01);
    sw[0] = 1'b1;
    step(1);
    sw[0] = 1'b0;
    step(2);
    sw[0] = 1'b1;
    step(12);

    // Key 2 held 30 cycles past its press pulse
    c = cyc;
    push(c + 6, 4'b0100, 4'b0100, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 10; k <= 34; k += 3) push(c + 6 + k, 4'b0100, 4'b0100, 2'b01);
`endif
    push(c + 42, 4'b0000, 4'b0000, 2'b01);
    key_n[2] = 1'b0;
    step(36);
    key_n[2] = 1'b1;
    step(12);

    // Same hold on key 0 never repeats
    c = cyc;
    push(c + 6, 4'b0001, 4'b0001, 2'b01);
    push(c + 42, 4'b0000, 4'b0000, 2'b01);
    key_n[0] = 1'b0;
    step(36);
    key_n[0] = 1'b1;
    step(12);

    // Reset while key 0 held; key and switch re-debounce afterwards
    c = cyc;
    push(c + 6, 4'b0001, 4'b0001, 2'b01);
    key_n[0] = 1'b0;
    step(10);
    push(c + 11, 4'b0000, 4'b0000, 2'b00);
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    c = cyc;
    push(c + 6, 4'b0001, 4'b0001, 2'b01);
    step(10);
    c = cyc;
    push(c + 6, 4'b0000, 4'b0000, 2'b00);
    key_n = 4'hF;
    sw    = 2'b00;
    step(10);

    #2 done = 1'b1;
    step(3);
    $display("FAIL timeout: monitor did not finish");
    $fatal(1);
  end

endmodule
